// File: rtl/bq_out_fifo.sv
// Decimating capture FIFO for biquad filter output samples, show-ahead read port.
// Define BQ_OUT_FIFO_OVF_CNT_EN to include the saturating dropped-sample counter.
module bq_out_fifo #(
   parameter int unsigned DATAWIDTH = 12,
   parameter int unsigned DEPTH     = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     en_i,
   input  logic [7:0]               decim_i,
   input  logic [DATAWIDTH-1:0]     y_i,
   input  logic                     y_vld_i,
   input  logic                     rd_i,
   input  logic                     clr_i,
   output logic [DATAWIDTH-1:0]     dat_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     ovf_o,
   output logic [7:0]               ovf_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DATAWIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [7:0]           dcnt;

   logic                 accept_c;
   logic                 capture_c;
   logic                 push_c;
   logic                 pop_c;
   logic                 drop_c;
   logic [7:0]           reload_c;
   logic [LW-1:0]        level_nxt_c;

   // Capture decision, push/pop qualification and next occupancy
   always_comb begin
      accept_c    = y_vld_i & en_i;
      capture_c   = accept_c & (dcnt == 8'd0);
      pop_c       = rd_i & ~empty_o;
      push_c      = capture_c & (~full_o | rd_i);
      drop_c      = capture_c & full_o & ~rd_i;
      reload_c    = (decim_i == 8'd0) ? 8'd0 : decim_i - 8'd1;
      level_nxt_c = level_o;
      case ({push_c, pop_c})
         2'b10:   level_nxt_c = level_o + LW'(1);
         2'b01:   level_nxt_c = level_o - LW'(1);
         default: level_nxt_c = level_o;
      endcase
   end

   // Control state; reset beats flush, flush beats push/pop
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clr_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
         empty_o <= 1'b1;
         full_o  <= 1'b0;
         ovf_o   <= 1'b0;
         dcnt    <= 8'd0;
      end else begin
         if (accept_c)
            dcnt <= (dcnt == 8'd0) ? reload_c : dcnt - 8'd1;
         if (push_c)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)
            rd_ptr <= rd_ptr + AW'(1);
         level_o <= level_nxt_c;
         empty_o <= (level_nxt_c == LW'(0));
         full_o  <= (level_nxt_c == LW'(DEPTH));
         if (drop_c)
            ovf_o <= 1'b1;
      end
   end

   // Storage is unreset; dat_o masks it whenever the FIFO is empty
   always_ff @(posedge wb_clk_i) begin
      if (push_c && !wb_rst_i && !clr_i)
         mem[wr_ptr] <= y_i;
   end

   assign dat_o = empty_o ? '0 : mem[rd_ptr];

`ifdef BQ_OUT_FIFO_OVF_CNT_EN
   logic [7:0] ovf_cnt_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clr_i)
         ovf_cnt_q <= 8'd0;
      else if (drop_c && ovf_cnt_q != 8'hFF)
         ovf_cnt_q <= ovf_cnt_q + 8'd1;
   end

   assign ovf_cnt_o = ovf_cnt_q;
`else
   assign ovf_cnt_o = 8'd0;
`endif

endmodule
